seg_display_arbiter: RTL

SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

---
 rtl/seg_disp_pkg.sv | 23 ++
 rtl/seg_scan_timer.sv | 46 ++++
 rtl/seg_display_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seg_disp_pkg.sv
// Shared constants, digit-select table and arbiter state encoding for the
// multiplexed seven-segment display arbiter.
package seg_disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] DIGIT_OFF = 4'hF;

  // Element d is the active-low enable pattern for digit d.
  localparam logic [3:0][3:0] DIGIT_SEL_TBL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  function automatic logic [2:0] lowest_req(input logic [2:0] r);
    if (r[0]) return 3'b001;
    if (r[1]) return 3'b010;
    if (r[2]) return 3'b100;
    return 3'b000;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot/digit scan timing: slot counter, digit index, drive window flag and a
// registered frame_done pulse following the last cycle of digit 3.
module seg_scan_timer
  import seg_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] digit_idx,
  output logic       drive,
  output logic       boundary,
  output logic       frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  if (BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_params
    $error("seg_scan_timer: BLANK_CYCLES must be smaller than REFRESH_DIV");
  end

  logic [CNT_W-1:0] slot_cnt;
  logic             slot_last;

  assign slot_last = (slot_cnt == CNT_W'(REFRESH_DIV - 1));
  assign drive     = (slot_cnt >= CNT_W'(BLANK_CYCLES));
  assign boundary  = slot_last && (digit_idx == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt   <= '0;
      digit_idx  <= 2'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (slot_last) begin
        slot_cnt  <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        slot_cnt <= slot_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Three-client arbiter for a 4-digit multiplexed display; ownership and the
// shadow frame only change at frame boundaries so a scan is never torn.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ARB_IDLE  | no owner; shadow frame blanked at each boundary
//   ARB_OWNED | grant holds the owner; shadow re-sampled at each boundary
module seg_display_arbiter
  import seg_disp_pkg::*;
#(
  parameter int REFRESH_DIV     = 50000,
  parameter int BLANK_CYCLES    = 500,
  parameter int MIN_HOLD_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [31:0] frame0,
  input  logic [31:0] frame1,
  input  logic [31:0] frame2,
  output logic [2:0]  grant,
  output logic        frame_done,
  output logic [3:0]  digit_sel,
  output logic [7:0]  segments
);

  localparam int HOLD_W = (MIN_HOLD_FRAMES > 0) ? $clog2(MIN_HOLD_FRAMES + 1) : 1;

  logic [1:0]  digit_idx;
  logic        drive;
  logic        boundary;

  arb_state_t  state, nxt_state;
  logic [2:0]  nxt_grant;
  logic [HOLD_W-1:0] hold_cnt, nxt_hold;
  logic [31:0] shadow, nxt_shadow;
  logic        owner_req;
  logic [2:0]  higher_req;

  seg_scan_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .digit_idx  (digit_idx),
    .drive      (drive),
    .boundary   (boundary),
    .frame_done (frame_done)
  );

  assign owner_req  = |(req & grant);
  // grant is one-hot, so grant-1 masks exactly the higher-priority clients
  assign higher_req = req & (grant - 3'd1);

  always_comb begin
    nxt_state = state;
    nxt_grant = grant;
    nxt_hold  = hold_cnt;
    unique case (state)
      ARB_IDLE: begin
        if (req != 3'b000) begin
          nxt_grant = lowest_req(req);
          nxt_hold  = '0;
          nxt_state = ARB_OWNED;
        end
      end
      ARB_OWNED: begin
        if (!owner_req) begin
          nxt_hold = '0;
          if (req != 3'b000) begin
            nxt_grant = lowest_req(req);
          end else begin
            nxt_grant = 3'b000;
            nxt_state = ARB_IDLE;
          end
        end else if ((higher_req != 3'b000) && (hold_cnt >= HOLD_W'(MIN_HOLD_FRAMES))) begin
          nxt_grant = lowest_req(higher_req);
          nxt_hold  = '0;
        end else if (hold_cnt < HOLD_W'(MIN_HOLD_FRAMES)) begin
          nxt_hold = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        nxt_state = ARB_IDLE;
        nxt_grant = 3'b000;
        nxt_hold  = '0;
      end
    endcase
  end

  always_comb begin
    nxt_shadow = {4{SEG_BLANK}};
    if (nxt_state == ARB_OWNED) begin
      case (nxt_grant)
        3'b001:  nxt_shadow = frame0;
        3'b010:  nxt_shadow = frame1;
        3'b100:  nxt_shadow = frame2;
        default: nxt_shadow = {4{SEG_BLANK}};
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARB_IDLE;
      grant    <= 3'b000;
      hold_cnt <= '0;
      shadow   <= {4{SEG_BLANK}};
    end else if (boundary) begin
      state    <= nxt_state;
      grant    <= nxt_grant;
      hold_cnt <= nxt_hold;
      shadow   <= nxt_shadow;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_sel <= DIGIT_OFF;
      segments  <= SEG_BLANK;
    end else if (drive) begin
      digit_sel <= DIGIT_SEL_TBL[digit_idx];
      segments  <= shadow[{digit_idx, 3'b000} +: 8];
    end else begin
      digit_sel <= DIGIT_OFF;
      segments  <= SEG_BLANK;
    end
  end

endmodule
